// File: rtl/irq_ctrl_pkg.sv
// Shared constants and state encoding for the external interrupt controller.
package irq_ctrl_pkg;

    localparam int IRQ_LINES = 64;
    localparam int IRQ_NUM_W = 6;

    localparam logic [1:0] ST_IDLE_ENC = 2'h0;
    localparam logic [1:0] ST_REQ_ENC  = 2'h1;
    localparam logic [1:0] ST_GAP_ENC  = 2'h2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE_ENC,
        REQ  = ST_REQ_ENC,
        GAP  = ST_GAP_ENC
    } irq_state_e;

endpackage

// File: rtl/irq_line_sync.sv
// One interrupt line: multi-flop synchronizer plus a delay flop for edge detection.
module irq_line_sync #(
    parameter int P_SYNC_STAGES = 2
) (
    input  logic iCLOCK,
    input  logic iRESET,
    input  logic irq,
    output logic sync,
    output logic sync_d
);

    logic [P_SYNC_STAGES-1:0] chain;

    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            chain  <= '0;
            sync_d <= 1'b0;
        end else begin
            chain  <= {chain[P_SYNC_STAGES-2:0], irq};
            sync_d <= chain[P_SYNC_STAGES-1];
        end
    end

    assign sync = chain[P_SYNC_STAGES-1];

endmodule

// File: rtl/external_irq_controller.sv
// Latches up to 64 device interrupt lines and offers them one at a time,
// lowest index first, to the core interrupt manager.
module external_irq_controller
    import irq_ctrl_pkg::*;
#(
    parameter int P_SYNC_STAGES = 2
) (
    input  logic                 iCLOCK,
    input  logic                 iRESET,
    input  logic [IRQ_LINES-1:0] iIRQ,
    input  logic [IRQ_LINES-1:0] iIRQ_ENABLE,
    input  logic [IRQ_LINES-1:0] iIRQ_EDGE,
    output logic                 oEXT_ACTIVE,
    output logic [IRQ_NUM_W-1:0] oEXT_NUM,
    input  logic                 iEXT_ACK,
    output logic [IRQ_LINES-1:0] oPENDING,
    output logic                 oBUSY
);

    localparam logic [IRQ_LINES-1:0] LINE0_MASK = {{(IRQ_LINES-1){1'b0}}, 1'b1};

    logic [IRQ_LINES-1:0] sync;
    logic [IRQ_LINES-1:0] sync_d;
    logic [IRQ_LINES-1:0] rise;
    logic [IRQ_LINES-1:0] pending;
    logic [IRQ_LINES-1:0] pending_next;
    logic [IRQ_LINES-1:0] in_service;
    logic [IRQ_LINES-1:0] in_service_next;
    logic [IRQ_LINES-1:0] cand;
    logic [IRQ_LINES-1:0] ack_vec;
    logic                 ack_take;

    irq_state_e           state;
    irq_state_e           state_next;
    logic                 active_next;
    logic [IRQ_NUM_W-1:0] num_next;

    function automatic logic [IRQ_NUM_W-1:0] lowest_index(input logic [IRQ_LINES-1:0] vec);
        logic [IRQ_NUM_W-1:0] idx;
        idx = '0;
        for (int i = IRQ_LINES - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = IRQ_NUM_W'(i);
            end
        end
        return idx;
    endfunction

    for (genvar g = 0; g < IRQ_LINES; g++) begin : g_line
        irq_line_sync #(
            .P_SYNC_STAGES(P_SYNC_STAGES)
        ) u_sync (
            .iCLOCK (iCLOCK),
            .iRESET (iRESET),
            .irq    (iIRQ[g]),
            .sync   (sync[g]),
            .sync_d (sync_d[g])
        );
    end

    assign rise     = sync & ~sync_d;
    assign ack_take = (state == REQ) && iEXT_ACK;
    assign ack_vec  = ack_take ? (LINE0_MASK << oEXT_NUM) : '0;
    assign cand     = pending & iIRQ_ENABLE;

    // A new edge beats a same-cycle ACK; a level line stays masked
    // from the ACK until its synchronized input is seen low.
    always_comb begin
        in_service_next = ~iIRQ_EDGE & sync & (in_service | ack_vec);
        pending_next    = (iIRQ_EDGE & (rise | (pending & ~ack_vec)))
                        | (~iIRQ_EDGE & sync & ~in_service_next);
    end

    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            pending    <= '0;
            in_service <= '0;
        end else begin
            pending    <= pending_next;
            in_service <= in_service_next;
        end
    end

    // Once issued, a request is held until ACK even if its line goes away.
    always_comb begin
        state_next  = state;
        active_next = oEXT_ACTIVE;
        num_next    = oEXT_NUM;
        case (state)
            IDLE: begin
                active_next = 1'b0;
                if (cand != '0) begin
                    num_next    = lowest_index(cand);
                    active_next = 1'b1;
                    state_next  = REQ;
                end
            end
            REQ: begin
                if (iEXT_ACK) begin
                    active_next = 1'b0;
                    state_next  = GAP;
                end
            end
            GAP: begin
                active_next = 1'b0;
                state_next  = IDLE;
            end
            default: begin
                active_next = 1'b0;
                state_next  = IDLE;
            end
        endcase
    end

    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            state       <= IDLE;
            oEXT_ACTIVE <= 1'b0;
            oEXT_NUM    <= '0;
        end else begin
            state       <= state_next;
            oEXT_ACTIVE <= active_next;
            oEXT_NUM    <= num_next;
        end
    end

    assign oPENDING = pending;
    assign oBUSY    = (state != IDLE);

endmodule

// File: tb/tb_external_irq_controller.sv
// Directed bench for external_irq_controller with a per-cycle reference model.
module tb_external_irq_controller;

    localparam int SYNC  = 2;
    localparam int LINES = 64;

    logic              iCLOCK = 1'b0;
    logic              iRESET = 1'b1;
    logic [LINES-1:0]  iIRQ = '0;
    logic [LINES-1:0]  iIRQ_ENABLE = ~(64'd1 << 12);
    logic [LINES-1:0]  iIRQ_EDGE = ~(64'd1 << 40);
    logic              oEXT_ACTIVE;
    logic [5:0]        oEXT_NUM;
    logic              iEXT_ACK = 1'b0;
    logic [LINES-1:0]  oPENDING;
    logic              oBUSY;

    int tests_run = 0;
    int tests_failed = 0;
    bit cmp_en = 1'b0;

    external_irq_controller #(
        .P_SYNC_STAGES(SYNC)
    ) dut (
        .iCLOCK      (iCLOCK),
        .iRESET      (iRESET),
        .iIRQ        (iIRQ),
        .iIRQ_ENABLE (iIRQ_ENABLE),
        .iIRQ_EDGE   (iIRQ_EDGE),
        .oEXT_ACTIVE (oEXT_ACTIVE),
        .oEXT_NUM    (oEXT_NUM),
        .iEXT_ACK    (iEXT_ACK),
        .oPENDING    (oPENDING),
        .oBUSY       (oBUSY)
    );

    always #5 iCLOCK = ~iCLOCK;

    // Reference model: hist[j] is iIRQ as sampled j clock edges ago.
    logic [LINES-1:0] hist [0:3];
    logic [LINES-1:0] m_pend = '0;
    logic [LINES-1:0] m_insvc = '0;
    int               m_phase = 0;
    logic             m_active = 1'b0;
    int               m_num = 0;

    initial begin
        for (int j = 0; j < 4; j++) hist[j] = '0;
        forever begin
            @(posedge iCLOCK or posedge iRESET);
            if (iRESET) begin
                for (int j = 0; j < 4; j++) hist[j] = '0;
                m_pend = '0;
                m_insvc = '0;
                m_phase = 0;
                m_active = 1'b0;
                m_num = 0;
            end else begin
                logic [LINES-1:0] np, ni, cnd;
                int ack_line;
                bit found;
                ack_line = (m_phase == 1 && iEXT_ACK) ? m_num : -1;
                for (int i = 0; i < LINES; i++) begin
                    bit s, sd, acked;
                    s = hist[SYNC-1][i];
                    sd = hist[SYNC][i];
                    acked = (i == ack_line);
                    if (iIRQ_EDGE[i]) begin
                        ni[i] = 1'b0;
                        np[i] = (s && !sd) || (m_pend[i] && !acked);
                    end else begin
                        ni[i] = s && (m_insvc[i] || acked);
                        np[i] = s && !ni[i];
                    end
                end
                cnd = m_pend & iIRQ_ENABLE;
                case (m_phase)
                    0: begin
                        found = 1'b0;
                        for (int i = 0; i < LINES; i++) begin
                            if (!found && cnd[i]) begin
                                found = 1'b1;
                                m_num = i;
                            end
                        end
                        if (found) begin
                            m_active = 1'b1;
                            m_phase = 1;
                        end
                    end
                    1: begin
                        if (iEXT_ACK) begin
                            m_active = 1'b0;
                            m_phase = 2;
                        end
                    end
                    default: m_phase = 0;
                endcase
                for (int j = 3; j > 0; j--) hist[j] = hist[j-1];
                hist[0] = iIRQ;
                m_pend = np;
                m_insvc = ni;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge iCLOCK) begin
        if (cmp_en) begin
            checkOutput("model_active", 64'(oEXT_ACTIVE), 64'(m_active));
            checkOutput("model_pending", oPENDING, m_pend);
            checkOutput("model_busy", 64'(oBUSY), 64'(m_phase != 0));
            if (m_active) checkOutput("model_num", 64'(oEXT_NUM), 64'(m_num));
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge iCLOCK);
            @(negedge iCLOCK);
        end
    endtask

    task automatic applyStimulus(input int line, input bit val);
        iIRQ[line] = val;
    endtask

    task automatic pulseLine(input int line);
        applyStimulus(line, 1'b1);
        tick();
        applyStimulus(line, 1'b0);
    endtask

    task automatic ackOnce();
        iEXT_ACK = 1'b1;
        tick();
        iEXT_ACK = 1'b0;
    endtask

    task automatic waitActive(input string name, input int max_cycles);
        int n;
        n = 0;
        while (!oEXT_ACTIVE && n < max_cycles) begin
            tick();
            n++;
        end
        checkOutput(name, 64'(oEXT_ACTIVE), 64'd1);
    endtask

    initial begin
        tick(2);
        checkOutput("reset_active", 64'(oEXT_ACTIVE), 64'd0);
        checkOutput("reset_num", 64'(oEXT_NUM), 64'd0);
        checkOutput("reset_pending", oPENDING, 64'd0);
        checkOutput("reset_busy", 64'(oBUSY), 64'd0);
        iRESET = 1'b0;
        cmp_en = 1'b1;
        tick(2);

        // Edge request on line 5: active after edge 3, counting the sampling edge as 0.
        pulseLine(5);
        tick(2);
        checkOutput("edge5_pending_e2", oPENDING[5], 64'd1);
        checkOutput("edge5_inactive_e2", 64'(oEXT_ACTIVE), 64'd0);
        tick();
        checkOutput("edge5_active_e3", 64'(oEXT_ACTIVE), 64'd1);
        checkOutput("edge5_num", 64'(oEXT_NUM), 64'd5);
        ackOnce();
        checkOutput("edge5_drop", 64'(oEXT_ACTIVE), 64'd0);
        checkOutput("edge5_cleared", oPENDING[5], 64'd0);
        checkOutput("edge5_gap_busy", 64'(oBUSY), 64'd1);
        tick();
        checkOutput("edge5_idle_busy", 64'(oBUSY), 64'd0);
        tick(2);

        // Priority between lines 3 and 9.
        iIRQ[3] = 1'b1;
        iIRQ[9] = 1'b1;
        tick();
        iIRQ[3] = 1'b0;
        iIRQ[9] = 1'b0;
        tick(3);
        checkOutput("prio_first_active", 64'(oEXT_ACTIVE), 64'd1);
        checkOutput("prio_first_num", 64'(oEXT_NUM), 64'd3);
        ackOnce();
        tick();
        checkOutput("prio_gap_low", 64'(oEXT_ACTIVE), 64'd0);
        tick();
        checkOutput("prio_second_active", 64'(oEXT_ACTIVE), 64'd1);
        checkOutput("prio_second_num", 64'(oEXT_NUM), 64'd9);
        ackOnce();
        tick(3);

        // Level line 40 held high must not retrigger after ACK.
        applyStimulus(40, 1'b1);
        waitActive("level40_first_wait", 10);
        checkOutput("level40_first_num", 64'(oEXT_NUM), 64'd40);
        ackOnce();
        for (int c = 0; c < 8; c++) begin
            checkOutput("level40_no_retrigger", 64'(oEXT_ACTIVE), 64'd0);
            tick();
        end
        checkOutput("level40_pending_masked", oPENDING[40], 64'd0);
        applyStimulus(40, 1'b0);
        tick(4);
        applyStimulus(40, 1'b1);
        waitActive("level40_second_wait", 10);
        checkOutput("level40_second_num", 64'(oEXT_NUM), 64'd40);
        ackOnce();
        applyStimulus(40, 1'b0);
        tick(5);

        // Disabled line 12 latches but is only requested once enabled.
        pulseLine(12);
        tick(5);
        checkOutput("en12_pending", oPENDING[12], 64'd1);
        checkOutput("en12_not_requested", 64'(oEXT_ACTIVE), 64'd0);
        iIRQ_ENABLE[12] = 1'b1;
        tick();
        checkOutput("en12_active", 64'(oEXT_ACTIVE), 64'd1);
        checkOutput("en12_num", 64'(oEXT_NUM), 64'd12);
        ackOnce();
        tick(3);

        // Stray ACK while idle.
        ackOnce();
        checkOutput("stray_active", 64'(oEXT_ACTIVE), 64'd0);
        checkOutput("stray_busy", 64'(oBUSY), 64'd0);
        checkOutput("stray_pending", oPENDING, 64'd0);
        tick(2);

        // New synchronized edge on line 7 lands on the same edge as its ACK.
        pulseLine(7);
        waitActive("sim7_first_wait", 10);
        checkOutput("sim7_first_num", 64'(oEXT_NUM), 64'd7);
        pulseLine(7);
        tick();
        ackOnce();
        checkOutput("sim7_pending_kept", oPENDING[7], 64'd1);
        checkOutput("sim7_drop", 64'(oEXT_ACTIVE), 64'd0);
        tick(2);
        checkOutput("sim7_again_active", 64'(oEXT_ACTIVE), 64'd1);
        checkOutput("sim7_again_num", 64'(oEXT_NUM), 64'd7);
        ackOnce();
        checkOutput("sim7_cleared", oPENDING[7], 64'd0);
        tick(3);

        // Asynchronous reset while a request is outstanding.
        pulseLine(5);
        waitActive("rst_req_wait", 10);
        #2;
        iRESET = 1'b1;
        #1;
        checkOutput("rst_async_active", 64'(oEXT_ACTIVE), 64'd0);
        checkOutput("rst_async_num", 64'(oEXT_NUM), 64'd0);
        checkOutput("rst_async_pending", oPENDING, 64'd0);
        checkOutput("rst_async_busy", 64'(oBUSY), 64'd0);
        @(negedge iCLOCK);
        iRESET = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            checkOutput("rst_quiet", 64'(oEXT_ACTIVE), 64'd0);
        end

        cmp_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
